// File: rtl/wb_sram_pkg.sv
// rtl/wb_sram_pkg.sv - Wishbone SRAM controller cycle-type codes and FSM state encoding
package wb_sram_pkg;

    // Wishbone registered-feedback cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    typedef logic [1:0] wb_sram_state_t;

    // Controller FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RACK = 2'd1;
    localparam logic [1:0] ST_WACK = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

endpackage

// File: rtl/wb_sram_ctrl.sv
// rtl/wb_sram_ctrl.sv - Wishbone slave to single-port SRAM bridge with linear bursts (optional WB_SRAM_ERR_EN range check)
module wb_sram_ctrl
    import wb_sram_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [31:0]           i_wb_adr,
    input  logic [31:0]           i_wb_dat,
    input  logic [3:0]            i_wb_sel,
    input  logic [2:0]            i_wb_cti,
    output logic                  o_wb_ack,
    output logic                  o_wb_err,
    output logic [31:0]           o_wb_dat,
    output logic                  o_ram_en,
    output logic [3:0]            o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [31:0]           o_ram_wdata,
    input  logic [31:0]           i_ram_rdata
);

    wb_sram_state_t        state;
    wb_sram_state_t        next_state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] next_cnt;
    logic [ADDR_WIDTH-1:0] cnt_inc;
    logic [ADDR_WIDTH-1:0] adr_word;
    logic                  req;
    logic                  in_window;

    assign req      = i_wb_cyc & i_wb_stb;
    assign adr_word = i_wb_adr[ADDR_WIDTH+1:2];
    assign cnt_inc  = cnt + 1'b1;

`ifdef WB_SRAM_ERR_EN
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << (ADDR_WIDTH + 2));

    assign in_window = ({1'b0, i_wb_adr} >= WIN_LO) && ({1'b0, i_wb_adr} < WIN_HI);
`else
    // Upper address bits alias onto the window when no range check is built in
    logic unused_adr_bits;

    assign in_window       = 1'b1;
    assign unused_adr_bits = ^{i_wb_adr[31:ADDR_WIDTH+2], i_wb_adr[1:0]};
`endif

    // Next-state, burst counter and all bus/RAM outputs; everything is forced idle while reset is high
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        o_wb_ack    = 1'b0;
        o_wb_err    = 1'b0;
        o_wb_dat    = 32'h0;
        o_ram_en    = 1'b0;
        o_ram_we    = 4'h0;
        o_ram_addr  = cnt;
        o_ram_wdata = 32'h0;
        if (!i_reset) begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        next_cnt = adr_word;
                        if (!in_window) begin
                            next_state = ST_ERR;
                        end else if (i_wb_we) begin
                            next_state = ST_WACK;
                        end else begin
                            // Read issued in the accept cycle so data is ready for the first ack
                            o_ram_en   = 1'b1;
                            o_ram_addr = adr_word;
                            next_state = ST_RACK;
                        end
                    end
                end
                ST_RACK: begin
                    if (req) begin
                        o_wb_ack = 1'b1;
                        o_wb_dat = i_ram_rdata;
                        if (i_wb_cti == CTI_INCR) begin
                            // Prefetch the next word so the following beat needs no wait
                            next_cnt   = cnt_inc;
                            o_ram_en   = 1'b1;
                            o_ram_addr = cnt_inc;
                        end else begin
                            next_state = ST_IDLE;
                        end
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
                ST_WACK: begin
                    if (req) begin
                        o_wb_ack    = 1'b1;
                        o_ram_en    = 1'b1;
                        o_ram_we    = i_wb_sel;
                        o_ram_addr  = cnt;
                        o_ram_wdata = i_wb_dat;
                        if (i_wb_cti == CTI_INCR) begin
                            next_cnt = cnt_inc;
                        end else begin
                            next_state = ST_IDLE;
                        end
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
                default: begin
                    o_wb_err   = req;
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State and word counter registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb/tb_wb_sram_ctrl.sv - directed self-checking bench for wb_sram_ctrl with a 1-cycle-latency SRAM model
module tb_wb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = 32'h0;
    logic [31:0] dat_w = 32'h0;
    logic [3:0]  sel = 4'h0;
    logic [2:0]  cti = 3'b000;
    logic        ack;
    logic        err;
    logic [31:0] dat_r;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    logic [31:0] mem [0:4095];

    int nvec  = 0;
    int nfail = 0;

    wb_sram_ctrl #(
        .ADDR_WIDTH (12),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_wb_cyc    (cyc),
        .i_wb_stb    (stb),
        .i_wb_we     (we),
        .i_wb_adr    (adr),
        .i_wb_dat    (dat_w),
        .i_wb_sel    (sel),
        .i_wb_cti    (cti),
        .o_wb_ack    (ack),
        .o_wb_err    (err),
        .o_wb_dat    (dat_r),
        .o_ram_en    (ram_en),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port SRAM, read data one cycle after enable, byte-lane writes
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'h0) begin
                ram_rdata <= mem[ram_addr];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic c, input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] se, input logic [2:0] ct);
        cyc = c; stb = s; we = w; adr = a; dat_w = d; sel = se; cti = ct;
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        for (int i = 0; i < 4; i++) mem[i] = i;
        mem[8] = 32'hAAAA_AAAA;
        mem[9] = 32'hBBBB_BBBB;

        // Reset held with a live read request: nothing may come out
        bus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
        sample();
        check("rst_ack", 32'(ack), 0);
        check("rst_err", 32'(err), 0);
        check("rst_ram_en", 32'(ram_en), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_dat", dat_r, 32'h0);
        tick();
        idle();
        rst = 1'b0;

        // Classic write to 0x10
        tick();
        bus(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000);
        sample();
        check("wr_accept_ack", 32'(ack), 0);
        check("wr_accept_en", 32'(ram_en), 0);
        tick();
        sample();
        check("wr_ack", 32'(ack), 1);
        check("wr_ram_en", 32'(ram_en), 1);
        check("wr_ram_we", 32'(ram_we), 32'hF);
        check("wr_ram_addr", 32'(ram_addr), 4);
        check("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
        tick();
        idle();
        sample();
        check("wr_done_ack", 32'(ack), 0);
        check("wr_mem4", mem[4], 32'hDEAD_BEEF);

        // Classic read of 0x10
        tick();
        bus(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 3'b000);
        sample();
        check("rd_accept_ack", 32'(ack), 0);
        check("rd_accept_en", 32'(ram_en), 1);
        check("rd_accept_we", 32'(ram_we), 0);
        check("rd_accept_addr", 32'(ram_addr), 4);
        tick();
        sample();
        check("rd_ack", 32'(ack), 1);
        check("rd_dat", dat_r, 32'hDEAD_BEEF);
        check("rd_ack_en", 32'(ram_en), 0);
        tick();
        idle();
        sample();
        check("rd_done_ack", 32'(ack), 0);
        check("rd_done_dat", dat_r, 32'h0);

        // 4-beat incrementing read burst from word 0
        tick();
        bus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010);
        sample();
        check("brd_accept_addr", 32'(ram_addr), 0);
        check("brd_accept_ack", 32'(ack), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            cti = (i < 3) ? 3'b010 : 3'b111;
            adr = 32'h0000_0F00;
            sample();
            check($sformatf("brd_ack%0d", i), 32'(ack), 1);
            check($sformatf("brd_dat%0d", i), dat_r, i);
            check($sformatf("brd_en%0d", i), 32'(ram_en), (i < 3) ? 1 : 0);
            if (i < 3) check($sformatf("brd_addr%0d", i), 32'(ram_addr), i + 1);
        end
        // A new classic request straight after end-of-burst must be treated as an accept
        tick();
        bus(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 3'b000);
        sample();
        check("brd_idle_ack", 32'(ack), 0);
        check("brd_idle_addr", 32'(ram_addr), 2);
        tick();
        sample();
        check("brd_next_dat", dat_r, 32'h2);
        tick();
        idle();

        // 2-beat write burst, low half-word lanes only
        tick();
        bus(1'b1, 1'b1, 1'b1, 32'h20, 32'h1111_2222, 4'h3, 3'b010);
        tick();
        sample();
        check("bwr_ack0", 32'(ack), 1);
        check("bwr_addr0", 32'(ram_addr), 8);
        check("bwr_we0", 32'(ram_we), 32'h3);
        tick();
        cti = 3'b111;
        adr = 32'h0000_0400;
        sample();
        check("bwr_ack1", 32'(ack), 1);
        check("bwr_addr1", 32'(ram_addr), 9);
        tick();
        idle();
        sample();
        check("bwr_mem8", mem[8], 32'hAAAA_2222);
        check("bwr_mem9", mem[9], 32'hBBBB_2222);

        // Strobe dropped after two read beats
        tick();
        bus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010);
        tick();
        sample();
        check("drop_dat0", dat_r, 32'h0);
        tick();
        sample();
        check("drop_dat1", dat_r, 32'h1);
        tick();
        stb = 1'b0;
        sample();
        check("drop_ack", 32'(ack), 0);
        check("drop_en", 32'(ram_en), 0);
        tick();
        bus(1'b1, 1'b1, 1'b0, 32'hC, 32'h0, 4'hF, 3'b000);
        sample();
        check("drop_idle_ack", 32'(ack), 0);
        check("drop_idle_addr", 32'(ram_addr), 3);
        tick();
        sample();
        check("drop_next_dat", dat_r, 32'h3);
        tick();
        idle();

        // Reset asserted in the middle of a read burst
        tick();
        bus(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 3'b010);
        tick();
        sample();
        check("mrst_ack0", 32'(ack), 1);
        tick();
        #1 rst = 1'b1;
        sample();
        check("mrst_ack", 32'(ack), 0);
        check("mrst_en", 32'(ram_en), 0);
        check("mrst_dat", dat_r, 32'h0);
        adr = 32'h4;
        cti = 3'b000;
        tick();
        rst = 1'b0;
        sample();
        check("mrst_accept_en", 32'(ram_en), 1);
        check("mrst_accept_addr", 32'(ram_addr), 1);
        tick();
        sample();
        check("mrst_first_ack", 32'(ack), 1);
        check("mrst_first_dat", dat_r, 32'h1);
        tick();
        idle();

        // Access just past the window: error when range-checked, alias of word 0 otherwise
        tick();
        bus(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 4'hF, 3'b000);
        sample();
        check("oow_accept_ack", 32'(ack), 0);
        check("oow_accept_err", 32'(err), 0);
`ifdef WB_SRAM_ERR_EN
        check("oow_accept_en", 32'(ram_en), 0);
        tick();
        sample();
        check("oow_err", 32'(err), 1);
        check("oow_ack", 32'(ack), 0);
        check("oow_en", 32'(ram_en), 0);
        tick();
        idle();
        sample();
        check("oow_err_clear", 32'(err), 0);
`else
        check("alias_en", 32'(ram_en), 1);
        check("alias_addr", 32'(ram_addr), 0);
        tick();
        sample();
        check("alias_ack", 32'(ack), 1);
        check("alias_err", 32'(err), 0);
        check("alias_dat", dat_r, 32'h0);
        tick();
        idle();
`endif

        // Burst counter wraps from the last word to word 0
        tick();
        bus(1'b1, 1'b1, 1'b1, 32'h3FFC, 32'h5A5A_A5A5, 4'hF, 3'b010);
        tick();
        sample();
        check("wrap_addr0", 32'(ram_addr), 32'hFFF);
        tick();
        cti = 3'b111;
        sample();
        check("wrap_addr1", 32'(ram_addr), 0);
        check("wrap_ack1", 32'(ack), 1);
        tick();
        idle();
        sample();
        check("wrap_mem0", mem[0], 32'h5A5A_A5A5);
        check("wrap_mem4095", mem[4095], 32'h5A5A_A5A5);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/wb_sram_ctrl.md
WB_SRAM_CTRL -- requirements
Module: wb_sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address bits of the attached SRAM (depth 2^ADDR_WIDTH words).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base address of the SRAM window.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_wb_cyc  input  1  Wishbone cycle.
REQ-006 SHALL have port i_wb_stb  input  1  Wishbone strobe.
REQ-007 SHALL have port i_wb_we  input  1  write enable.
REQ-008 SHALL have port i_wb_adr  input  32  byte address.
REQ-009 SHALL have port i_wb_dat  input  32  write data.
REQ-010 SHALL have port i_wb_sel  input  4  byte lane select.
REQ-011 SHALL have port i_wb_cti  input  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst.
REQ-012 SHALL have port o_wb_ack  output  1  acknowledge.
REQ-013 SHALL have port o_wb_err  output  1  bus error.
REQ-014 SHALL have port o_wb_dat  output  32  read data.
REQ-015 SHALL have ports o_ram_en (output, 1), o_ram_we (output, 4, byte write enables), o_ram_addr (output, ADDR_WIDTH, word address), o_ram_wdata (output, 32) and i_ram_rdata (input, 32, valid the cycle after a read enable).

Function
REQ-016 SHALL implement states IDLE, RACK, WACK, ERR.
REQ-017 Accept SHALL occur in IDLE when i_wb_cyc & i_wb_stb; the internal word counter loads i_wb_adr[ADDR_WIDTH+1:2].
REQ-018 Read accept SHALL drive o_ram_en=1, o_ram_we=0 and o_ram_addr=i_wb_adr word combinationally in the accept cycle, then go to RACK.
REQ-019 Write accept SHALL issue no RAM access and go to WACK.
REQ-020 o_wb_ack SHALL equal (state is RACK or WACK) & i_wb_cyc & i_wb_stb.
REQ-021 In RACK with ack, o_wb_dat SHALL equal i_ram_rdata; otherwise o_wb_dat SHALL be 32'h0.
REQ-022 In WACK with ack, the block SHALL drive o_ram_en=1, o_ram_we=i_wb_sel, o_ram_wdata=i_wb_dat, o_ram_addr=counter.
REQ-023 In an ack cycle with i_wb_cti=010, the counter SHALL increment, the state SHALL hold, and in RACK the next read SHALL be issued at counter+1 in the same cycle, giving one beat per cycle after the first.
REQ-024 In an ack cycle with i_wb_cti other than 010, the state SHALL return to IDLE.
REQ-025 Latency SHALL be: first beat acked 1 cycle after accept; subsequent burst beats 0 extra cycles.
REQ-026 Burst addressing SHALL be linear; i_wb_adr SHALL be ignored after accept; the counter SHALL wrap modulo 2^ADDR_WIDTH.
REQ-027 If i_wb_cyc or i_wb_stb is low in RACK/WACK, there SHALL be no ack, no RAM enable, and the next state SHALL be IDLE; a prefetched read word is discarded.
REQ-028 o_wb_ack and o_wb_err SHALL never be asserted together.

Reset
REQ-029 i_reset SHALL immediately force state IDLE, counter 0, o_wb_ack=0, o_wb_err=0, o_ram_en=0, o_ram_we=0, o_wb_dat=0, including mid-burst.
REQ-030 After reset release, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-031 With WB_SRAM_ERR_EN defined, an accept whose address lies outside [BASE_ADDR, BASE_ADDR+4*2^ADDR_WIDTH-1] SHALL enter ERR, assert o_wb_err for one cycle gated by cyc&stb, issue no RAM access, then go to IDLE.
REQ-032 Without WB_SRAM_ERR_EN, there SHALL be no range check, address bits above ADDR_WIDTH+1 SHALL be ignored (aliasing), and o_wb_err SHALL be tied 0.

Structure
REQ-033 Package wb_sram_pkg SHALL hold the CTI code constants (CTI_CLASSIC, CTI_INCR, CTI_EOB) and the FSM state encoding.
REQ-034 The controller SHALL be a single module with no sub-module; the SRAM array is external, and the bench uses a behavioural single-port model with 1-cycle read latency.

Verification
REQ-035 Classic write to BASE+0x10, dat 32'hDEADBEEF, sel 4'hF -> ack 1 cycle after strobe, RAM word 4 = DEADBEEF.
REQ-036 Classic read of BASE+0x10 -> ack on the 2nd strobe cycle, o_wb_dat = 32'hDEADBEEF.
REQ-037 4-beat read from word 0, cti 010,010,010,111, words preset 0..3 -> acks on 4 consecutive cycles after 1-cycle latency, data 0,1,2,3, then IDLE.
REQ-038 2-beat write burst, sel 4'h3, dat 32'h1111_2222 -> only bytes [15:0] updated in words n and n+1.
REQ-039 Strobe dropped after beat 2 of a read burst -> no further ack, o_ram_en=0, IDLE; i_reset asserted mid-burst -> o_wb_ack=0 in the same cycle.
REQ-040 With WB_SRAM_ERR_EN and ADDR_WIDTH=12, access to BASE+32'h4000 -> o_wb_err for 1 cycle, no ack, o_ram_en never asserted.
